sha_msched: RTL

Parametrised SHA-2 message-schedule engine for the Versat accelerator datapath. It holds a 16-word sliding window loaded over the unit memory-mapped bus and expands it into ROUNDS schedule words W[t], one per accepted cycle, under a valid/ready stream handshake. It generalises the fixed single-step schedule stage to SHA-256 or SHA-512 widths, arbitrary round counts and downstream backpressure. It reports `done` on the accelerator run/done convention.

---
 rtl/sha_msched_pkg.sv | 53 +++++
 rtl/sha_sigma.sv | 23 ++
 rtl/sha_msched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sha_msched_pkg.sv
// Shared types and constants for the SHA-2 message-schedule engine.
package sha_msched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Lower = sigma0, upper = sigma1.
    typedef enum logic {
        SigLower,
        SigUpper
    } sigma_sel_e;

    localparam int unsigned WIN_DEPTH   = 16;
    localparam int unsigned STATUS_ADDR = 16;

    // Rotate/shift amounts: {rotr_a, rotr_b, shr}.
    localparam int unsigned SIG256_L_R1 = 7;
    localparam int unsigned SIG256_L_R2 = 18;
    localparam int unsigned SIG256_L_SH = 3;
    localparam int unsigned SIG256_U_R1 = 17;
    localparam int unsigned SIG256_U_R2 = 19;
    localparam int unsigned SIG256_U_SH = 10;
    localparam int unsigned SIG512_L_R1 = 1;
    localparam int unsigned SIG512_L_R2 = 8;
    localparam int unsigned SIG512_L_SH = 7;
    localparam int unsigned SIG512_U_R1 = 19;
    localparam int unsigned SIG512_U_R2 = 61;
    localparam int unsigned SIG512_U_SH = 6;

    // idx 0/1 = rotate amounts, 2 = shift amount.
    function automatic int unsigned sigma_amt(int unsigned data_w, sigma_sel_e sel,
                                              int unsigned idx);
        int unsigned amt;
        if (data_w == 64) begin
            if (sel == SigLower) begin
                amt = (idx == 0) ? SIG512_L_R1 : (idx == 1) ? SIG512_L_R2 : SIG512_L_SH;
            end else begin
                amt = (idx == 0) ? SIG512_U_R1 : (idx == 1) ? SIG512_U_R2 : SIG512_U_SH;
            end
        end else begin
            if (sel == SigLower) begin
                amt = (idx == 0) ? SIG256_L_R1 : (idx == 1) ? SIG256_L_R2 : SIG256_L_SH;
            end else begin
                amt = (idx == 0) ? SIG256_U_R1 : (idx == 1) ? SIG256_U_R2 : SIG256_U_SH;
            end
        end
        return amt;
    endfunction

endpackage

// File: rtl/sha_sigma.sv
// Combinational SHA-2 small sigma (sigma0 or sigma1) for 32- or 64-bit words.
module sha_sigma
    import sha_msched_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter sigma_sel_e  SEL    = SigLower
) (
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_y
);

    localparam int unsigned R1 = sigma_amt(DATA_W, SEL, 0);
    localparam int unsigned R2 = sigma_amt(DATA_W, SEL, 1);
    localparam int unsigned SH = sigma_amt(DATA_W, SEL, 2);

    // Two rotations and one logical shift, XOR-combined.
    always_comb begin
        o_y = ((i_x >> R1) | (i_x << (DATA_W - R1)))
            ^ ((i_x >> R2) | (i_x << (DATA_W - R2)))
            ^ (i_x >> SH);
    end

endmodule

// File: rtl/sha_msched.sv
// SHA-2 message-schedule engine: bus-loaded 16-word window expanded into ROUNDS
// schedule words over a valid/ready stream.
module sha_msched
    import sha_msched_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_run,
    output logic                  o_done,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W/8-1:0]   i_wstrb,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic                  o_ready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [DATA_W-1:0]     o_w_out,
    output logic                  o_w_valid,
    input  logic                  i_w_ready,
    output logic [7:0]            o_round_idx
);

    state_e              r_state;
    state_e              w_state_next;
    logic [DATA_W-1:0]   r_win [WIN_DEPTH];
    logic [7:0]          r_t;
    logic                r_ready;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_running;
    logic                w_hs;
    logic                w_last;
    logic                w_in_win;
    logic                w_bus_wr;
    logic [3:0]          w_win_idx;
    logic [DATA_W-1:0]   w_sig0;
    logic [DATA_W-1:0]   w_sig1;
    logic [DATA_W-1:0]   w_win_new;
    logic [14:0]         w_status;
    logic [DATA_W-1:0]   w_rd_val;

    sha_sigma #(
        .DATA_W (DATA_W),
        .SEL    (SigLower)
    ) u_sigma0 (
        .i_x (r_win[1]),
        .o_y (w_sig0)
    );

    sha_sigma #(
        .DATA_W (DATA_W),
        .SEL    (SigUpper)
    ) u_sigma1 (
        .i_x (r_win[14]),
        .o_y (w_sig1)
    );

    // Handshake, bus decode and the new tail word of the window.
    always_comb begin
        w_running = (r_state == StRun);
        w_hs      = w_running & i_w_ready;
        w_last    = w_hs && (r_t == 8'(ROUNDS - 1));
        w_in_win  = (i_addr < ADDR_W'(STATUS_ADDR));
        w_win_idx = i_addr[3:0];
        // Writes during a run are acknowledged but dropped.
        w_bus_wr  = i_valid & (|i_wstrb) & ~w_running & w_in_win;
        w_win_new = w_sig1 + r_win[9] + w_sig0 + r_win[0];
        w_status  = {r_t, 6'b0, w_running};
        w_rd_val  = '0;
        if (w_in_win) begin
            w_rd_val = r_win[w_win_idx];
        end else if (i_addr == ADDR_W'(STATUS_ADDR)) begin
            w_rd_val = DATA_W'(w_status);
        end
    end

    // Next-state logic: run starts from IDLE/DONE, the final handshake ends the run.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StDone: if (i_run) w_state_next = StRun;
            StRun:          if (w_last) w_state_next = StDone;
            default:        w_state_next = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round counter: cleared on start, advanced per accepted word.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_t <= '0;
        end else if (!w_running && i_run) begin
            r_t <= '0;
        end else if (w_hs) begin
            r_t <= r_t + 8'd1;
        end
    end

    // Window: shifts on handshake while running, bus-writable otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < WIN_DEPTH; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_hs) begin
            for (int unsigned i = 0; i < WIN_DEPTH - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_win_new;
        end else if (w_bus_wr) begin
            r_win[w_win_idx] <= i_wdata;
        end
    end

    // Registered bus response; rdata is zero whenever ready is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= i_valid;
            r_rdata <= i_valid ? w_rd_val : '0;
        end
    end

    // Output mapping.
    always_comb begin
        o_done      = ~w_running;
        o_w_valid   = w_running;
        o_w_out     = r_win[0];
        o_round_idx = r_t;
        o_ready     = r_ready;
        o_rdata     = r_rdata;
    end

endmodule
